divider_seq_n: RTL and testbench

//  Sequential unsigned restoring divider. Computes a/b in nb_bit iterations.

---
 rtl/divider_pkg.sv | 21 ++
 rtl/divider_seq_n_if.sv | 44 ++++
 rtl/subtractor_n.sv | 28 ++
 rtl/divider_seq_n.sv | 132 +++++++++++++
 tb/tb_divider_seq_n.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared declarations for the sequential restoring divider.
//   div_state_t : FSM encoding (IDLE accepts work, BUSY iterates, DONE holds the result)
//   cnt_width() : width of the iteration counter for a given operand width
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // The counter has to hold nb_bit-1 down to 0. A width of at least 1 keeps
    // the vector legal for the smallest operand width (nb_bit == 2).
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/divider_seq_n_if.sv
// Request/result handshake bundle for divider_seq_n.
//   start_i / a_i / b_i            : request side (accepted when start_i & ready_o)
//   ready_o                        : divider is idle and can accept a request
//   valid_o / ack_i                : result handshake (held until valid_o & ack_i)
//   quotient_o / remainder_o       : result operands
//   div_zero_o                     : divide-by-zero flag, qualified by valid_o
// The "slave" modport is the divider; "master" is the requester/consumer.
interface divider_seq_n_if #(
    parameter int nb_bit = 8
);
    logic              start_i;
    logic [nb_bit-1:0] a_i;
    logic [nb_bit-1:0] b_i;
    logic              ready_o;
    logic              valid_o;
    logic              ack_i;
    logic [nb_bit-1:0] quotient_o;
    logic [nb_bit-1:0] remainder_o;
    logic              div_zero_o;

    modport slave (
        input  start_i,
        input  a_i,
        input  b_i,
        input  ack_i,
        output ready_o,
        output valid_o,
        output quotient_o,
        output remainder_o,
        output div_zero_o
    );

    modport master (
        output start_i,
        output a_i,
        output b_i,
        output ack_i,
        input  ready_o,
        input  valid_o,
        input  quotient_o,
        input  remainder_o,
        input  div_zero_o
    );
endinterface

// File: rtl/subtractor_n.sv
// Unsigned ripple-borrow subtractor.
//   a_i, b_i  : operands (nb_bit wide)
//   diff_o    : a_i - b_i modulo 2**nb_bit
//   borrow_o  : 1 when b_i > a_i
// Purely combinational.
module subtractor_n #(
    parameter int nb_bit = 9
) (
    input  logic [nb_bit-1:0] a_i,
    input  logic [nb_bit-1:0] b_i,
    output logic [nb_bit-1:0] diff_o,
    output logic              borrow_o
);

    logic [nb_bit:0] borrow_chain;

    assign borrow_chain[0] = 1'b0;

    for (genvar gi = 0; gi < nb_bit; gi++) begin : g_bit
        assign diff_o[gi]         = a_i[gi] ^ b_i[gi] ^ borrow_chain[gi];
        // Borrow out when b > a at this bit, or they are equal and a borrow ripples in.
        assign borrow_chain[gi+1] = (~a_i[gi] & b_i[gi])
                                  | (~(a_i[gi] ^ b_i[gi]) & borrow_chain[gi]);
    end

    assign borrow_o = borrow_chain[nb_bit];

endmodule

// File: rtl/divider_seq_n.sv
// Sequential unsigned restoring divider: quotient = a / b, remainder = a % b.
// One bit of quotient is produced per cycle using a single shared subtractor.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : request/result handshake (see divider_seq_n_if)
// Timing: a request accepted on edge 1 presents valid_o after edge nb_bit+1;
// a zero divisor short-circuits straight to DONE after edge 1.
// All outputs are decoded from flops only; no input reaches an output combinationally.
module divider_seq_n
    import divider_pkg::*;
#(
    parameter int nb_bit = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    divider_seq_n_if.slave         bus
);

    localparam int CNT_W = cnt_width(nb_bit);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(nb_bit - 1);

    div_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [nb_bit-1:0] p_q, p_d;      // partial remainder
    logic [nb_bit-1:0] q_q, q_d;      // dividend shifting out / quotient shifting in
    logic [nb_bit-1:0] d_q, d_d;      // divisor
    logic              dz_q, dz_d;    // divide-by-zero flag

    // Shared subtractor: trial-subtract the divisor from the shifted partial remainder.
    logic [nb_bit:0]   sub_a;
    logic [nb_bit:0]   sub_b;
    logic [nb_bit:0]   sub_diff;
    logic              sub_borrow;
    logic              sub_diff_msb_unused;

    assign sub_a = {p_q, q_q[nb_bit-1]};
    assign sub_b = {1'b0, d_q};

    subtractor_n #(
        .nb_bit (nb_bit + 1)
    ) u_sub (
        .a_i      (sub_a),
        .b_i      (sub_b),
        .diff_o   (sub_diff),
        .borrow_o (sub_borrow)
    );

    // When no borrow occurs the result is below the divisor, so its top bit is always 0.
    assign sub_diff_msb_unused = sub_diff[nb_bit];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        dz_d    = dz_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    d_d   = bus.b_i;
                    q_d   = bus.a_i;
                    p_d   = '0;
                    cnt_d = CNT_LOAD;
                    dz_d  = 1'b0;
                    if (bus.b_i == '0) begin
                        // Divide by zero: all-ones quotient, dividend as remainder.
                        q_d     = '1;
                        p_d     = bus.a_i;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end

            BUSY: begin
                if (!sub_borrow) begin
                    p_d = sub_diff[nb_bit-1:0];
                    q_d = {q_q[nb_bit-2:0], 1'b1};
                end else begin
                    // Restore: keep the shifted partial remainder unchanged.
                    p_d = sub_a[nb_bit-1:0];
                    q_d = {q_q[nb_bit-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DONE: begin
                if (bus.ack_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            dz_q    <= dz_d;
        end
    end

    // No ack->start pass-through: ready only in IDLE.
    assign bus.ready_o     = (state_q == IDLE);
    assign bus.valid_o     = (state_q == DONE);
    assign bus.quotient_o  = q_q;
    assign bus.remainder_o = p_q;
    assign bus.div_zero_o  = dz_q;

endmodule

// File: tb/tb_divider_seq_n.sv
`timescale 1ns/1ps
module tb_divider_seq_n;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    divider_seq_n_if #(.nb_bit(8)) ifc ();

    divider_seq_n #(.nb_bit(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble inputs after acceptance, wait for valid,
    // hold for ack_dly cycles, then acknowledge. Latency counts the acceptance edge as 1.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int ack_dly,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic dz, output int lat);
        int n;
        @(negedge clk);
        ifc.start_i = 1'b1;
        ifc.a_i     = a;
        ifc.b_i     = b;
        check("ready_before_start", 32'(ifc.ready_o), 32'd1);
        @(posedge clk);
        n = 1;
        @(negedge clk);
        ifc.start_i = 1'b0;
        ifc.a_i     = 8'($urandom);
        ifc.b_i     = 8'($urandom);
        while (!ifc.valid_o && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        lat = n;
        q   = ifc.quotient_o;
        r   = ifc.remainder_o;
        dz  = ifc.div_zero_o;
        repeat (ack_dly) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("valid_held", 32'(ifc.valid_o), 32'd1);
        ifc.ack_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.ack_i = 1'b0;
        check("idle_after_ack", 32'(ifc.ready_o), 32'd1);
    endtask

    task automatic sweep_op(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q, r;
        logic       dz;
        int         lat;
        run_op(a, b, int'($urandom_range(0, 3)), q, r, dz, lat);
        if (b == 8'd0) begin
            check("sweep_dz_lat", 32'(lat), 32'd1);
            check("sweep_dz_q", 32'(q), 32'hFF);
            check("sweep_dz_r", 32'(r), 32'(a));
            check("sweep_dz_flag", 32'(dz), 32'd1);
        end else begin
            check("sweep_lat", 32'(lat), 32'd9);
            check("sweep_invariant", 32'(int'(q) * int'(b) + int'(r)), 32'(a));
            check("sweep_r_lt_b", 32'(r < b), 32'd1);
            check("sweep_flag", 32'(dz), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] q, r;
        logic       dz;
        int         lat;
        int         n;

        tests = 0;
        fails = 0;
        rst_n       = 1'b0;
        ifc.start_i = 1'b0;
        ifc.a_i     = '0;
        ifc.b_i     = '0;
        ifc.ack_i   = 1'b0;

        // Reset state
        #1;
        check("rst_ready", 32'(ifc.ready_o), 32'd1);
        check("rst_valid", 32'(ifc.valid_o), 32'd0);
        check("rst_q", 32'(ifc.quotient_o), 32'd0);
        check("rst_r", 32'(ifc.remainder_o), 32'd0);
        check("rst_dz", 32'(ifc.div_zero_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 200/7 with inputs and ack toggled while busy, then held result
        @(negedge clk);
        ifc.start_i = 1'b1;
        ifc.a_i     = 8'd200;
        ifc.b_i     = 8'd7;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        check("ready_drop", 32'(ifc.ready_o), 32'd0);
        while (!ifc.valid_o && n < 40) begin
            ifc.start_i = 1'($urandom);
            ifc.a_i     = 8'($urandom);
            ifc.b_i     = 8'($urandom);
            ifc.ack_i   = 1'($urandom);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        ifc.ack_i   = 1'b0;
        ifc.start_i = 1'b0;
        check("200_7_lat", 32'(n), 32'd9);
        check("200_7_q", 32'(ifc.quotient_o), 32'd28);
        check("200_7_r", 32'(ifc.remainder_o), 32'd4);
        check("200_7_dz", 32'(ifc.div_zero_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            ifc.start_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(ifc.valid_o), 32'd1);
            check("hold_ready", 32'(ifc.ready_o), 32'd0);
            check("hold_q", 32'(ifc.quotient_o), 32'd28);
            check("hold_r", 32'(ifc.remainder_o), 32'd4);
        end
        ifc.start_i = 1'b0;
        ifc.ack_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.ack_i = 1'b0;
        check("ack_ready", 32'(ifc.ready_o), 32'd1);
        check("ack_valid", 32'(ifc.valid_o), 32'd0);

        // Directed corner divisions
        run_op(8'd5, 8'd9, 0, q, r, dz, lat);
        check("5_9_q", 32'(q), 32'd0);
        check("5_9_r", 32'(r), 32'd5);
        check("5_9_lat", 32'(lat), 32'd9);
        run_op(8'd255, 8'd1, 0, q, r, dz, lat);
        check("255_1_q", 32'(q), 32'd255);
        check("255_1_r", 32'(r), 32'd0);
        run_op(8'd255, 8'd255, 1, q, r, dz, lat);
        check("255_255_q", 32'(q), 32'd1);
        check("255_255_r", 32'(r), 32'd0);
        run_op(8'd77, 8'd0, 2, q, r, dz, lat);
        check("77_0_lat", 32'(lat), 32'd1);
        check("77_0_q", 32'(q), 32'hFF);
        check("77_0_r", 32'(r), 32'd77);
        check("77_0_dz", 32'(dz), 32'd1);
        run_op(8'd9, 8'd3, 0, q, r, dz, lat);
        check("9_3_dz_cleared", 32'(dz), 32'd0);
        check("9_3_q", 32'(q), 32'd3);

        // Reset in the middle of an operation
        @(negedge clk);
        ifc.start_i = 1'b1;
        ifc.a_i     = 8'd100;
        ifc.b_i     = 8'd3;
        @(posedge clk);
        @(negedge clk);
        ifc.start_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(ifc.ready_o), 32'd1);
        check("midrst_valid", 32'(ifc.valid_o), 32'd0);
        check("midrst_q", 32'(ifc.quotient_o), 32'd0);
        check("midrst_r", 32'(ifc.remainder_o), 32'd0);
        check("midrst_dz", 32'(ifc.div_zero_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd100, 8'd3, 0, q, r, dz, lat);
        check("100_3_q", 32'(q), 32'd33);
        check("100_3_r", 32'(r), 32'd1);
        check("100_3_lat", 32'(lat), 32'd9);

        // Sweep: every divisor once, then random operands, then every dividend once
        for (int i = 0; i < 256; i++) begin
            sweep_op(8'($urandom), 8'(i));
        end
        for (int i = 0; i < 200; i++) begin
            sweep_op(8'($urandom), 8'($urandom_range(1, 20)));
        end
        for (int i = 0; i < 256; i++) begin
            sweep_op(8'(i), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
